if_fetch: RTL and testbench

Instruction-fetch stage directly downstream of the PC register. Each cycle it takes the PC and predicted-taken bit, looks the PC up in a direct-mapped instruction cache and, on a hit, hands the word to the IF/ID latch one cycle later. On a miss it stalls the front end and assembles the word from the byte-wide memory controller port, then fills the cache. A mispredict flush aborts any delivery and restarts fetch cleanly.

---
 rtl/if_fetch_pkg.sv | 30 +++
 rtl/if_fetch_icache_dm.sv | 51 +++++
 rtl/if_fetch.sv | 151 +++++++++++++++
 tb/tb_if_fetch.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg
// Shared widths, constants, FSM state codes and address-split helpers for the
// instruction-fetch stage and its direct-mapped instruction cache.
//   ICACHE_LINES : number of one-word cache lines (power of two)
//   INDEX_W      : log2(ICACHE_LINES), index taken from pc[2+INDEX_W-1:2]
//   TAG_W        : tag width, taken from pc[31:2+INDEX_W]
package if_fetch_pkg;

  localparam int ICACHE_LINES = 128;
  localparam int INDEX_W      = 7;
  localparam int TAG_W        = 32 - 2 - INDEX_W;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic        NOT_STOP  = 1'b0;

  typedef enum logic [1:0] {
    IF_IDLE    = 2'd0,
    IF_FILL    = 2'd1,
    IF_DISCARD = 2'd2
  } if_state_e;

  function automatic logic [INDEX_W-1:0] pc_index(input logic [31:0] pc);
    return pc[2+INDEX_W-1:2];
  endfunction

  function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
    return pc[31:2+INDEX_W];
  endfunction

endpackage

// File: rtl/if_fetch_icache_dm.sv
// icache_dm
// Direct-mapped, one-word-per-line instruction cache storage.
//   clk_i       : clock, write port is synchronous
//   rst_ni      : asynchronous active-low clear of all valid bits
//   rd_index_i  : lookup line index (asynchronous read)
//   rd_tag_i    : lookup tag, compared against the stored tag
//   hit_o       : line valid and tag matches
//   rd_data_o   : stored word of the looked-up line
//   wr_en_i     : write enable for the fill port
//   wr_index_i  : line to fill
//   wr_tag_i    : tag to store
//   wr_data_i   : word to store
module icache_dm
  import if_fetch_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [INDEX_W-1:0] rd_index_i,
  input  logic [TAG_W-1:0]   rd_tag_i,
  output logic               hit_o,
  output logic [31:0]        rd_data_o,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] wr_index_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [31:0]        wr_data_i
);

  logic [ICACHE_LINES-1:0] valid_q;
  logic [TAG_W-1:0]        tag_q  [ICACHE_LINES];
  logic [31:0]             data_q [ICACHE_LINES];

  // Only the valid bits need clearing; tag/data contents are don't-care until valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  assign hit_o     = valid_q[rd_index_i] && (tag_q[rd_index_i] == rd_tag_i);
  assign rd_data_o = data_q[rd_index_i];

endmodule

// File: rtl/if_fetch.sv
// if_fetch
// Instruction-fetch stage: looks pc_in up in a direct-mapped I-cache, forwards
// hits to the IF/ID latch one edge later, and on a miss stalls the front end
// while a 4-byte word is assembled from the byte-wide memory port.
//   clk_in / rst_in      : clock, asynchronous active-low reset
//   rdy_in               : global enable, 0 freezes all state
//   stall[1]             : freezes the IF/ID outputs
//   flush_in             : kills the current fetch (mispredict)
//   pc_in, pre_taken_in  : fetch address and its prediction bit
//   stallreq_o           : word for pc_in not available this cycle
//   mem_req_o/mem_addr_o : word-aligned read request to the memory controller
//   mem_byte_in/mem_valid_in : returned bytes, little-endian order
//   if_pc_o/if_inst_o/if_pre_taken_o/if_valid_o : IF/ID latch contents
module if_fetch
  import if_fetch_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [5:0]  stall,
  input  logic        flush_in,
  input  logic [31:0] pc_in,
  input  logic        pre_taken_in,
  output logic        stallreq_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic [7:0]  mem_byte_in,
  input  logic        mem_valid_in,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_pre_taken_o,
  output logic        if_valid_o
);

  if_state_e state_q, state_d;

  logic [1:0]  cnt_q;
  logic [23:0] buf_q;
  logic [29:0] addr_q;

  logic        hit;
  logic [31:0] rd_data;
  logic        last_byte;
  logic        cache_we;
  logic        unused_inputs;

  assign unused_inputs = ^{stall[5:2], stall[0], pc_in[1:0]};

  assign last_byte  = mem_valid_in && (cnt_q == 2'd3);
  assign mem_addr_o = {addr_q, 2'b00};

  icache_dm u_icache (
    .clk_i      (clk_in),
    .rst_ni     (rst_in),
    .rd_index_i (pc_index(pc_in)),
    .rd_tag_i   (pc_tag(pc_in)),
    .hit_o      (hit),
    .rd_data_o  (rd_data),
    .wr_en_i    (cache_we),
    .wr_index_i (addr_q[INDEX_W-1:0]),
    .wr_tag_i   (addr_q[29:INDEX_W]),
    .wr_data_i  ({mem_byte_in, buf_q})
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IF_IDLE;
    end else if (rdy_in) begin
      state_q <= state_d;
    end
  end

  // DISCARD still runs the burst to completion because the controller never
  // aborts a started burst; it differs from FILL only in intent.
  always_comb begin
    state_d = state_q;
    if (rdy_in) begin
      unique case (state_q)
        IF_IDLE:    if (!hit) state_d = IF_FILL;
        IF_FILL: begin
          if (last_byte)     state_d = IF_IDLE;
          else if (flush_in) state_d = IF_DISCARD;
        end
        IF_DISCARD: if (last_byte) state_d = IF_IDLE;
        default:    state_d = IF_IDLE;
      endcase
    end
  end

  // The request is simply "a burst is open"; it therefore drops on the edge
  // that accepts the 4th byte and freezes along with the state when rdy_in=0.
  always_comb begin
    mem_req_o  = 1'b0;
    stallreq_o = 1'b1;
    cache_we   = 1'b0;
    mem_req_o  = (state_q != IF_IDLE);
    stallreq_o = !hit || (state_q != IF_IDLE);
    cache_we   = rdy_in && (state_q != IF_IDLE) && last_byte;
  end

  // The 4th byte bypasses buf_q straight into the cache write data.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q  <= 2'd0;
      buf_q  <= '0;
      addr_q <= '0;
    end else if (rdy_in) begin
      if (state_q == IF_IDLE) begin
        if (!hit) begin
          addr_q <= pc_in[31:2];
          cnt_q  <= 2'd0;
        end
      end else if (mem_valid_in) begin
        cnt_q <= cnt_q + 2'd1;
        case (cnt_q)
          2'd0:    buf_q[7:0]   <= mem_byte_in;
          2'd1:    buf_q[15:8]  <= mem_byte_in;
          2'd2:    buf_q[23:16] <= mem_byte_in;
          default: buf_q        <= buf_q;
        endcase
      end
    end
  end

  // Flush beats stall; otherwise an unstalled cycle either forwards a hit or
  // inserts a bubble. PC and prediction bit are left as-is on bubbles.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      if_pc_o        <= ZERO_WORD;
      if_inst_o      <= ZERO_WORD;
      if_pre_taken_o <= 1'b0;
      if_valid_o     <= 1'b0;
    end else if (rdy_in) begin
      if (flush_in) begin
        if_inst_o  <= ZERO_WORD;
        if_valid_o <= 1'b0;
      end else if (stall[1] == NOT_STOP) begin
        if (!stallreq_o) begin
          if_pc_o        <= pc_in;
          if_inst_o      <= rd_data;
          if_pre_taken_o <= pre_taken_in;
          if_valid_o     <= 1'b1;
        end else begin
          if_inst_o  <= ZERO_WORD;
          if_valid_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch
// Self-checking bench for if_fetch. A behavioural model keeps the cache as
// plain arrays of (valid, tag, word) plus "a burst is open at address A with n
// bytes received", and predicts every output each cycle. The bench also plays
// the memory controller, returning bytes of memWord(addr) in little-endian order.
module tb_if_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic [5:0]  stall = '0;
  logic        flush_in = 1'b0;
  logic [31:0] pc_in = '0;
  logic        pre_taken_in = 1'b0;
  logic        stallreq_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_byte_in = '0;
  logic        mem_valid_in = 1'b0;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_pre_taken_o;
  logic        if_valid_o;

  int nVec = 0;
  int nErr = 0;

  // Reference model state
  bit          mV [128];
  logic [22:0] mT [128];
  logic [31:0] mD [128];
  bit          mBusy;
  int          mCnt;
  logic [31:0] mAddr;
  logic        eReq;
  logic [31:0] eAddr;
  logic [31:0] ePc;
  logic [31:0] eInst;
  logic        ePt;
  logic        eValid;

  logic [31:0] curPc;

  if_fetch dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .stall          (stall),
    .flush_in       (flush_in),
    .pc_in          (pc_in),
    .pre_taken_in   (pre_taken_in),
    .stallreq_o     (stallreq_o),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_byte_in    (mem_byte_in),
    .mem_valid_in   (mem_valid_in),
    .if_pc_o        (if_pc_o),
    .if_inst_o      (if_inst_o),
    .if_pre_taken_o (if_pre_taken_o),
    .if_valid_o     (if_valid_o)
  );

  // 10-unit clock
  always #5 clk_in = ~clk_in;

  // Memory image: word at address 0 is 0x00000013 (addi x0,x0,0)
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'h0000_0013;
  endfunction

  // One comparison: counts it, and on mismatch counts and reports the failure
  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Everything the model knows is cleared the same way a reset clears the DUT
  task automatic modelReset();
    for (int i = 0; i < 128; i++) mV[i] = 0;
    mBusy  = 0;
    mCnt   = 0;
    mAddr  = '0;
    eReq   = 1'b0;
    eAddr  = '0;
    ePc    = '0;
    eInst  = '0;
    ePt    = 1'b0;
    eValid = 1'b0;
  endtask

  // Compare all registered outputs against the model
  task automatic checkOutput();
    checkVal("mem_req",   32'(mem_req_o), 32'(eReq));
    checkVal("mem_addr",  mem_addr_o, eAddr);
    checkVal("if_pc",     if_pc_o, ePc);
    checkVal("if_inst",   if_inst_o, eInst);
    checkVal("if_pt",     32'(if_pre_taken_o), 32'(ePt));
    checkVal("if_valid",  32'(if_valid_o), 32'(eValid));
  endtask

  // Drive one cycle of inputs, check the combinational stall request, take the
  // edge, advance the model and check the registered outputs afterwards
  task automatic applyStimulus(input logic [31:0] pc, input logic pt, input logic fl,
                               input logic st1, input logic rdy, input logic mv);
    logic [6:0]  idx;
    logic [22:0] tg;
    logic [6:0]  fi;
    bit          hit;
    logic [31:0] w;
    logic [5:0]  stv;
    if (mBusy) begin
      w = memWord(mAddr) >> (8 * mCnt);
      mem_byte_in = w[7:0];
    end else begin
      mem_byte_in = 8'($urandom);
    end
    stv          = 6'($urandom);
    stv[1]       = st1;
    stall        = stv;
    pc_in        = pc;
    pre_taken_in = pt;
    flush_in     = fl;
    rdy_in       = rdy;
    mem_valid_in = mv;
    #1;
    idx = pc[8:2];
    tg  = pc[31:9];
    hit = mV[idx] && (mT[idx] == tg);
    checkVal("stallreq", 32'(stallreq_o), 32'(!hit || mBusy));
    @(posedge clk_in);
    if (rdy) begin
      if (fl) begin
        eValid = 1'b0;
        eInst  = '0;
      end else if (!st1) begin
        if (!mBusy && hit) begin
          ePc    = pc;
          eInst  = mD[idx];
          ePt    = pt;
          eValid = 1'b1;
        end else begin
          eValid = 1'b0;
          eInst  = '0;
        end
      end
      if (mBusy) begin
        if (mv) begin
          mCnt++;
          if (mCnt == 4) begin
            fi     = mAddr[8:2];
            mV[fi] = 1;
            mT[fi] = mAddr[31:9];
            mD[fi] = memWord(mAddr);
            mBusy  = 0;
            eReq   = 1'b0;
          end
        end
      end else if (!hit) begin
        mBusy = 1;
        mCnt  = 0;
        mAddr = {pc[31:2], 2'b00};
        eReq  = 1'b1;
        eAddr = mAddr;
      end
    end
    #1;
    checkOutput();
  endtask

  // Miss at pc, then four back-to-back bytes, then the re-lookup hit
  task automatic fillAndHit(input logic [31:0] pc, input logic pt);
    applyStimulus(pc, pt, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(pc, pt, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(pc, pt, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Directed scenarios followed by a randomized run
  initial begin
    logic [31:0] pool [8];
    int          reqCycles;
    int          sel;
    logic        mv;

    modelReset();
    repeat (2) @(posedge clk_in);
    #1;
    checkOutput();
    rst_in = 1'b1;
    $display("[TB] reset released");

    // Cold miss at 0x0 with back-to-back bytes
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("cold_addr", mem_addr_o, 32'h0);
    reqCycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_req_o) reqCycles++;
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    checkVal("cold_req_cycles", 32'(reqCycles), 32'd4);
    checkVal("cold_req_drop", 32'(mem_req_o), 32'd0);
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("cold_inst", if_inst_o, 32'h0000_0013);
    checkVal("cold_pc", if_pc_o, 32'h0);
    checkVal("cold_valid", 32'(if_valid_o), 32'd1);

    // Warm hit
    applyStimulus(32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("warm_req", 32'(mem_req_o), 32'd0);
    checkVal("warm_valid", 32'(if_valid_o), 32'd1);

    // Flush two bytes into a fill at 0x100
    applyStimulus(32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(32'h100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkVal("discard_novalid", 32'(if_valid_o), 32'd0);
    applyStimulus(32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkVal("discard_done_req", 32'(mem_req_o), 32'd0);
    applyStimulus(32'h100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("after_discard_inst", if_inst_o, memWord(32'h100));

    // Aliasing 0x200 onto the 0x0 line, then 0x0 misses again
    fillAndHit(32'h200, 1'b0);
    checkVal("alias_inst", if_inst_o, memWord(32'h200));
    fillAndHit(32'h0, 1'b0);
    checkVal("realias_inst", if_inst_o, 32'h0000_0013);

    // Stall holds outputs during a hit; flush beats the stall
    fillAndHit(32'h104, 1'b0);
    applyStimulus(32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'h104, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkVal("stall_hold_pc", if_pc_o, 32'h0);
    applyStimulus(32'h104, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkVal("stall_flush_valid", 32'(if_valid_o), 32'd0);

    // Asynchronous reset in the middle of a fill
    applyStimulus(32'h300, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'h300, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    rst_in = 1'b0;
    modelReset();
    #1;
    checkOutput();
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    applyStimulus(32'h300, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("post_reset_miss_req", 32'(mem_req_o), 32'd1);

    // Randomized traffic over a small, aliasing-rich address pool
    pool[0] = 32'h0000_0000;
    pool[1] = 32'h0000_0200;
    pool[2] = 32'h0000_0100;
    pool[3] = 32'h0000_0104;
    pool[4] = 32'h0000_0300;
    pool[5] = 32'h8000_0004;
    pool[6] = 32'h0000_0008;
    pool[7] = 32'h1234_5008;
    curPc = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 3) begin
        sel   = int'($urandom_range(0, 7));
        curPc = pool[sel] | 32'($urandom_range(0, 3));
      end
      if (mBusy) mv = ($urandom_range(0, 1) == 0);
      else       mv = ($urandom_range(0, 7) == 0);
      applyStimulus(curPc, 1'($urandom), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) != 0), mv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
